bit_op_sequencer: RTL
=====================

BIT_OP_SEQUENCER -- requirements
Module: bit_op_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, meaning the operand width in bits (legal 4..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1, meaning the block accepts a command this cycle.
REQ-006 SHALL have port cmd_op, input, 3, with encodings 000 INV, 001 SHL, 010 SHR, 011 ROL, 100 ROR; 101-111 are illegal.
REQ-007 SHALL have port cmd_data, input, WORD_SIZE, carrying the operand.
REQ-008 SHALL have port cmd_amt, input, 4, carrying the bit position for INV or the step count for the shift and rotate ops.
REQ-009 SHALL have port rsp_valid, output, 1, meaning a result is held.
REQ-010 SHALL have port rsp_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port rsp_data, output, WORD_SIZE, carrying the result.
REQ-012 SHALL have port rsp_err, output, 1, flagging an illegal op or an out-of-range INV position.
REQ-013 SHALL have ports zero_flag, carry_flag and overflow_flag, each output, 1, as registered status of the last completed command.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, EXEC and DONE.
REQ-016 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 A command SHALL be accepted when cmd_valid and cmd_ready are both 1: the block latches op, data and amt, and loads the step counter with amt.
REQ-018 On accept, the block SHALL go IDLE->DONE when the op is INV, illegal, or has amt==0; otherwise it SHALL go IDLE->EXEC.
REQ-019 In EXEC, each cycle SHALL apply one 1-bit step (SHL: LSB<=0; SHR: MSB<=0; ROL/ROR: circular) and decrement the counter; on the cycle the counter reaches 0 the state SHALL go EXEC->DONE.
REQ-020 Latency SHALL be amt+1 cycles from the accept edge to rsp_valid=1 for shift and rotate ops, and 1 cycle for INV, illegal ops and amt==0.
REQ-021 In DONE, rsp_valid SHALL be 1 and rsp_data, rsp_err and the flags SHALL hold stable until rsp_ready=1, then the state SHALL go DONE->IDLE; the next command SHALL be accepted no earlier than the cycle after that.
REQ-022 INV SHALL invert bit cmd_amt; when cmd_amt>=WORD_SIZE, rsp_err SHALL be 1 and the data SHALL pass through unchanged.
REQ-023 An illegal op SHALL give rsp_err=1, data unchanged, carry_flag=0 and overflow_flag=0.
REQ-024 Step counts greater than WORD_SIZE SHALL execute fully: shifts end at 0, and rotates wrap modulo WORD_SIZE.
REQ-025 zero_flag SHALL equal (rsp_data==0).
REQ-026 carry_flag SHALL be the bit shifted or rotated out on the final step, and 0 for INV and for amt==0.
REQ-027 All flags SHALL update only on the edge that enters DONE and hold otherwise.
REQ-028 cmd_valid asserted while not in IDLE SHALL be ignored, with no side effect.

Reset
REQ-029 While reset=0, the block SHALL immediately force: state IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, all flags=0 and counter=0.
REQ-030 Reset asserted during EXEC or DONE SHALL discard the command in flight without producing a response.
REQ-031 After reset deasserts, the first command SHALL be accepted on the first rising edge at which cmd_valid=1.

Configuration
REQ-032 With macro BITOPS_OVERFLOW_EN defined, overflow_flag SHALL be 1 when any SHL step changes the MSB, and 0 for all other ops.
REQ-033 Without BITOPS_OVERFLOW_EN defined, overflow_flag SHALL be tied to 0 and its tracking logic SHALL be absent.

Verification
REQ-034 SHL 8'hCC amt=1 -> rsp_data=8'h98, carry=1, zero=0, rsp_valid 2 cycles after accept.
REQ-035 ROR 8'hCC amt=1 -> 8'h66, carry=0; ROL 8'hCC amt=9 -> 8'h99, carry=1, busy for 10 cycles.
REQ-036 INV 8'hAA amt=3 -> 8'hA2, rsp_err=0; INV amt=9 -> 8'hAA, rsp_err=1.
REQ-037 SHR 8'h01 amt=1 -> 8'h00, zero=1, carry=1; SHL 8'h40 amt=1 -> 8'h80, overflow=1 with BITOPS_OVERFLOW_EN defined and overflow=0 without it.
REQ-038 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable, cmd_ready=0 and a second cmd_valid is ignored; release rsp_ready -> IDLE next cycle.
REQ-039 Assert reset=0 on the 3rd EXEC cycle of SHR amt=6 -> all outputs go to reset values at once, no response is produced, and a new command is accepted after release.

Source files
------------

// File: rtl/bit_op_sequencer.sv
// -----------------------------------------------------------------------------
// bit_op_sequencer
//
// Purpose:
//   Accepts one bit-manipulation command at a time (INV, SHL, SHR, ROL, ROR),
//   executes shifts and rotates one bit per clock, and holds the result with
//   status flags until the consumer takes it.
//
// Handshake (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   cmd_ready is 1 only in IDLE. rsp_valid is 1 only in DONE, where the result
//   and flags hold stable until rsp_ready is seen high.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_data[WORD_SIZE-1:0], cmd_amt[3:0]
//   rsp_valid/rsp_ready, rsp_data[WORD_SIZE-1:0], rsp_err
//   zero_flag, carry_flag, overflow_flag (status of last completed command)
//   busy (state != IDLE), dbg_state (raw FSM state for observation)
//
// Configuration:
//   BITOPS_OVERFLOW_EN - when defined, overflow_flag reports whether any SHL
//   step changed the MSB; when undefined, overflow_flag is tied to 0.
// -----------------------------------------------------------------------------
module bit_op_sequencer #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [WORD_SIZE-1:0] cmd_data,
    input  logic [3:0]           cmd_amt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 zero_flag,
    output logic                 carry_flag,
    output logic                 overflow_flag,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_INV = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_SHR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [4:0] WORD_SIZE_5 = 5'(WORD_SIZE);

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;

    logic [WORD_SIZE-1:0]   step_data;
    logic                   step_out;
    logic [WORD_SIZE-1:0]   inv_mask;
    logic                   accept;
    logic                   exec_last;

    // One-bit step of the latched op; step_out is the bit leaving the word.
    always_comb begin
        step_data = data_q;
        step_out  = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_data = {data_q[WORD_SIZE-2:0], 1'b0};
                step_out  = data_q[WORD_SIZE-1];
            end
            OP_SHR: begin
                step_data = {1'b0, data_q[WORD_SIZE-1:1]};
                step_out  = data_q[0];
            end
            OP_ROL: begin
                step_data = {data_q[WORD_SIZE-2:0], data_q[WORD_SIZE-1]};
                step_out  = data_q[WORD_SIZE-1];
            end
            OP_ROR: begin
                step_data = {data_q[0], data_q[WORD_SIZE-1:1]};
                step_out  = data_q[0];
            end
            default: begin
                step_data = data_q;
                step_out  = 1'b0;
            end
        endcase
    end

    assign inv_mask  = {{(WORD_SIZE-1){1'b0}}, 1'b1} << cmd_amt;
    assign accept    = (state_q == IDLE) && cmd_valid;
    assign exec_last = (state_q == EXEC) && (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        zero_d  = zero_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    cnt_d = cmd_amt;
                    if (cmd_op == OP_INV) begin
                        // Out-of-range position passes the operand through.
                        if ({1'b0, cmd_amt} < WORD_SIZE_5) begin
                            data_d = cmd_data ^ inv_mask;
                            err_d  = 1'b0;
                        end else begin
                            data_d = cmd_data;
                            err_d  = 1'b1;
                        end
                        zero_d  = (data_d == '0);
                        carry_d = 1'b0;
                        state_d = DONE;
                    end else if (cmd_op > OP_ROR) begin
                        data_d  = cmd_data;
                        err_d   = 1'b1;
                        zero_d  = (cmd_data == '0);
                        carry_d = 1'b0;
                        state_d = DONE;
                    end else if (cmd_amt == 4'd0) begin
                        data_d  = cmd_data;
                        err_d   = 1'b0;
                        zero_d  = (cmd_data == '0);
                        carry_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        data_d  = cmd_data;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                data_d = step_data;
                cnt_d  = cnt_q - 4'd1;
                if (exec_last) begin
                    err_d   = 1'b0;
                    zero_d  = (step_data == '0);
                    carry_d = step_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            data_q  <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

`ifdef BITOPS_OVERFLOW_EN
    logic ovf_acc_q, ovf_acc_d;
    logic ovf_q, ovf_d;
    logic ovf_acc_next;

    // Sticky record of any SHL step that flipped the MSB during this command.
    always_comb begin
        ovf_acc_next = ovf_acc_q;
        if ((state_q == EXEC) && (op_q == OP_SHL) &&
            (step_data[WORD_SIZE-1] != data_q[WORD_SIZE-1])) begin
            ovf_acc_next = 1'b1;
        end
        ovf_acc_d = ovf_acc_next;
        ovf_d     = ovf_q;
        if (accept) begin
            ovf_acc_d = 1'b0;
            // Commands finishing straight from IDLE never shift.
            if (state_d == DONE) begin
                ovf_d = 1'b0;
            end
        end
        if (exec_last) begin
            ovf_d = ovf_acc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign overflow_flag = ovf_q;
`else
    assign overflow_flag = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign dbg_state  = state_q;

endmodule
